// File: rtl/cnn_image_streamer.sv
// cnn_image_streamer
// Source end of the CNN classifier pixel-stream interface. A host preloads one
// IMG_SIZE x IMG_SIZE image into the internal buffer and pulses go; the block
// then raises cnn_start, streams the pixels in raster order with a programmable
// inter-pixel gap, waits for cnn_done and latches the predicted class.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   load_we/addr/data   image buffer write port (accepted only while idle)
//   go                  start-frame pulse (accepted only while idle)
//   gap_cycles          idle cycles between pixels, latched at go
//   busy                high whenever the FSM is not idle
//   result_valid        one-cycle pulse when result_class is updated
//   result_class        class of the last successful frame
//   timeout             sticky, set when cnn_done never arrives; cleared by go
//   frame_count         successfully completed frames (wraps)
//   cnn_start           classifier enable, high from ARM through WAIT_DONE
//   cnn_pixel           pixel data to the classifier
//   cnn_pixel_valid     pixel qualifier
//   cnn_done            classifier done (only observed in WAIT_DONE)
//   cnn_predicted_class classifier argmax result
//
// State      | meaning
// IDLE       | accept buffer writes and go
// ARM        | cnn_start raised, pixel 0 read from the buffer
// STREAM     | present pixels 1..NPIX-1 separated by the latched gap
// WAIT_DONE  | wait for cnn_done, bounded by TIMEOUT_CYCLES
// RESULT     | result_valid pulse, cnn_start dropped for one cycle

module cnn_image_streamer #(
  parameter int IMG_SIZE       = 28,
  parameter int PIXEL_WIDTH    = 8,
  parameter int GAP_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_we,
  input  logic [9:0]             load_addr,
  input  logic [PIXEL_WIDTH-1:0] load_data,
  input  logic                   go,
  input  logic [GAP_WIDTH-1:0]   gap_cycles,
  output logic                   busy,
  output logic                   result_valid,
  output logic [3:0]             result_class,
  output logic                   timeout,
  output logic [15:0]            frame_count,
  output logic                   cnn_start,
  output logic [PIXEL_WIDTH-1:0] cnn_pixel,
  output logic                   cnn_pixel_valid,
  input  logic                   cnn_done,
  input  logic [3:0]             cnn_predicted_class
);

  localparam int NPIX   = IMG_SIZE * IMG_SIZE;
  localparam int MEM_AW = $clog2(NPIX);
  localparam int IDX_W  = $clog2(NPIX + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [10:0]       NPIX_ADDR = 11'(NPIX);
  localparam logic [IDX_W-1:0]  NPIX_IDX  = IDX_W'(NPIX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ARM, STREAM, WAIT_DONE, RESULT} state_t;

  state_t                 state;
  logic [PIXEL_WIDTH-1:0] mem [NPIX];
  logic [IDX_W-1:0]       idx;
  logic [GAP_WIDTH-1:0]   gap_lat;
  logic [GAP_WIDTH-1:0]   gap_cnt;
  logic [WAIT_W-1:0]      wait_cnt;

  assign busy = (state != IDLE);

  // Image buffer: no reset, writable only while idle so a frame in flight
  // always streams the image that was present at go.
  always_ff @(posedge clk) begin
    if (state == IDLE && load_we && ({1'b0, load_addr} < NPIX_ADDR))
      mem[load_addr[MEM_AW-1:0]] <= load_data;
  end

  // cnn_pixel is the buffer's synchronous read register, so it naturally
  // holds the last presented pixel through the gap cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      result_valid    <= 1'b0;
      result_class    <= '0;
      timeout         <= 1'b0;
      frame_count     <= '0;
      cnn_start       <= 1'b0;
      cnn_pixel       <= '0;
      cnn_pixel_valid <= 1'b0;
      idx             <= '0;
      gap_lat         <= '0;
      gap_cnt         <= '0;
      wait_cnt        <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            gap_lat   <= gap_cycles;
            timeout   <= 1'b0;
            cnn_start <= 1'b1;
            state     <= ARM;
          end
        end
        ARM: begin
          cnn_pixel       <= mem[0];
          cnn_pixel_valid <= 1'b1;
          idx             <= IDX_W'(1);
          gap_cnt         <= gap_lat;
          state           <= STREAM;
        end
        STREAM: begin
          // The last pixel leaves immediately for WAIT_DONE; no trailing gap.
          if (idx == NPIX_IDX) begin
            cnn_pixel_valid <= 1'b0;
            wait_cnt        <= '0;
            state           <= WAIT_DONE;
          end else if (gap_cnt != '0) begin
            cnn_pixel_valid <= 1'b0;
            gap_cnt         <= gap_cnt - GAP_WIDTH'(1);
          end else begin
            cnn_pixel       <= mem[idx[MEM_AW-1:0]];
            cnn_pixel_valid <= 1'b1;
            idx             <= idx + IDX_W'(1);
            gap_cnt         <= gap_lat;
          end
        end
        WAIT_DONE: begin
          // done is tested first so it wins over a coincident timeout
          if (cnn_done) begin
            result_class <= cnn_predicted_class;
            result_valid <= 1'b1;
            frame_count  <= frame_count + 16'd1;
            cnn_start    <= 1'b0;
            state        <= RESULT;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout   <= 1'b1;
            cnn_start <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        RESULT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_image_streamer.sv
// Self-checking bench for cnn_image_streamer. A behavioural model (image array,
// per-frame timing formulas) predicts every output on every cycle of a frame.
// Cycle numbering: cyc counts rising edges; values are sampled 2 time units
// after edge cyc, so they are the values registered at that edge.
module tb_cnn_image_streamer;

  localparam int NPIX = 784;
  localparam int TOUT = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_we;
  logic [9:0]  load_addr;
  logic [7:0]  load_data;
  logic        go;
  logic [3:0]  gap_cycles;
  logic        busy;
  logic        result_valid;
  logic [3:0]  result_class;
  logic        timeout;
  logic [15:0] frame_count;
  logic        cnn_start;
  logic [7:0]  cnn_pixel;
  logic        cnn_pixel_valid;
  logic        cnn_done;
  logic [3:0]  cnn_predicted_class;

  always #5 clk = ~clk;

  cnn_image_streamer #(
    .IMG_SIZE(28), .PIXEL_WIDTH(8), .GAP_WIDTH(4), .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .go(go), .gap_cycles(gap_cycles),
    .busy(busy), .result_valid(result_valid), .result_class(result_class),
    .timeout(timeout), .frame_count(frame_count),
    .cnn_start(cnn_start), .cnn_pixel(cnn_pixel), .cnn_pixel_valid(cnn_pixel_valid),
    .cnn_done(cnn_done), .cnn_predicted_class(cnn_predicted_class)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // reference model state
  logic [7:0]  ref_mem [NPIX];
  logic [15:0] exp_fc    = '0;
  logic [3:0]  exp_class = '0;
  logic [7:0]  exp_last  = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic load_px(input int a, input logic [7:0] d);
    load_we   = 1'b1;
    load_addr = a[9:0];
    load_data = d;
    if (a < NPIX) ref_mem[a] = d;
    step();
    load_we = 1'b0;
  endtask

  // One frame. j > 0: cnn_done is sampled on the j-th WAIT_DONE edge.
  // j <= 0: cnn_done never arrives and the frame times out.
  task automatic run_frame(input int g, input int j, input logic [3:0] cls,
                           input bit poke, input bit w0_en, input logic [7:0] w0);
    logic [7:0] snap [NPIX];
    int T, L, D, TOC, end_c, r;
    bit done_mode, is_pix, e_start, e_busy, e_rv, e_to;

    gap_cycles = g[3:0];
    go = 1'b1;
    if (w0_en) begin
      load_we   = 1'b1;
      load_addr = '0;
      load_data = w0;
      ref_mem[0] = w0;   // same-cycle write lands before the frame reads it
    end
    snap = ref_mem;
    step();
    go = 1'b0;
    load_we = 1'b0;
    gap_cycles = 4'($urandom);   // must not matter: gap is latched at go

    T         = cyc;
    L         = T + 1 + (NPIX - 1) * (g + 1);  // last pixel visible
    done_mode = (j > 0);
    D         = L + 1 + j;
    TOC       = L + 1 + TOUT;
    end_c     = done_mode ? D + 1 : TOC;

    for (int c = T; c <= end_c; c++) begin
      r      = c - T - 1;
      is_pix = (r >= 0) && (r % (g + 1) == 0) && (r / (g + 1) < NPIX);
      if (is_pix) exp_last = snap[r / (g + 1)];
      e_start = done_mode ? (c < D) : (c < TOC);
      e_busy  = done_mode ? (c <= D) : (c < TOC);
      e_rv    = done_mode && (c == D);
      e_to    = !done_mode && (c == TOC);
      if (e_rv) begin
        exp_fc    = exp_fc + 16'd1;
        exp_class = cls;
      end
      chk("pix_valid", cnn_pixel_valid, is_pix);
      chk("pix_data", cnn_pixel, exp_last);
      chk("cnn_start", cnn_start, e_start);
      chk("busy", busy, e_busy);
      chk("result_valid", result_valid, e_rv);
      chk("timeout", timeout, e_to);
      chk("frame_count", frame_count, exp_fc);
      chk("result_class", result_class, exp_class);
      if (c < end_c) begin
        // drive inputs for edge c+1
        cnn_predicted_class = 4'($urandom);
        cnn_done = (c + 1 <= L + 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
        go = 1'b0;
        load_we = 1'b0;
        if (poke && (c + 1 == T + 50)) begin
          go = 1'b1;
          load_we = 1'b1;
          load_addr = '0;
          load_data = 8'hFF;
          cnn_done = 1'b1;
          cnn_predicted_class = 4'd3;
        end
        if (done_mode && (c + 1 == D)) begin
          cnn_done = 1'b1;
          cnn_predicted_class = cls;
        end
        step();
      end
    end
    cnn_done = 1'b0;
    go = 1'b0;
    load_we = 1'b0;
  endtask

  task automatic reset_mid_stream();
    logic [7:0] p300;
    p300 = ref_mem[300];
    gap_cycles = 4'd0;
    go = 1'b1;
    step();
    go = 1'b0;
    begin
      int T;
      T = cyc;
      while (cyc < T + 301) step();
    end
    chk("rst_pix300_valid", cnn_pixel_valid, 1'b1);
    chk("rst_pix300_data", cnn_pixel, p300);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_start", cnn_start, 1'b0);
    chk("rst_async_valid", cnn_pixel_valid, 1'b0);
    chk("rst_async_busy", busy, 1'b0);
    chk("rst_async_rv", result_valid, 1'b0);
    exp_fc = '0;
    exp_class = '0;
    exp_last = '0;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_after_busy", busy, 1'b0);
    chk("rst_after_fc", frame_count, exp_fc);
    chk("rst_after_start", cnn_start, 1'b0);
    chk("rst_after_class", result_class, exp_class);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    load_we = 1'b0;
    load_addr = '0;
    load_data = '0;
    go = 1'b0;
    gap_cycles = '0;
    cnn_done = 1'b0;
    cnn_predicted_class = '0;
    step();
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rv", result_valid, 1'b0);
    chk("rst_class", result_class, 4'd0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_fc", frame_count, 16'd0);
    chk("rst_start", cnn_start, 1'b0);
    chk("rst_pixel", cnn_pixel, 8'd0);
    chk("rst_valid", cnn_pixel_valid, 1'b0);
    rst = 1'b0;
    step();

    // ramp image, plus out-of-range writes that must be dropped
    for (int i = 0; i < NPIX; i++) load_px(i, 8'(i % 256));
    load_px(784, 8'hAA);
    load_px(1023, 8'h55);

    // gap 0: j=15 puts the done edge at go+800 (last pixel at go+784)
    run_frame(0, 15, 4'd7, 1'b0, 1'b0, 8'h00);
    // gap 2 with go/write/early-done poked mid-stream
    run_frame(2, 5, 4'd9, 1'b1, 1'b0, 8'h00);
    // back-to-back: original buffer[0] must still stream
    run_frame(1, 1, 4'd12, 1'b0, 1'b0, 8'h00);
    // timeout, then a frame whose done coincides with the timeout cycle
    run_frame(0, 0, 4'd0, 1'b0, 1'b0, 8'h00);
    run_frame(0, TOUT, 4'd5, 1'b0, 1'b0, 8'h00);

    // randomized frames with random images and go+write to address 0
    for (int f = 0; f < 3; f++) begin
      for (int w = 0; w < 200; w++)
        load_px($urandom_range(0, 1023), 8'($urandom));
      run_frame($urandom_range(0, 3), $urandom_range(1, TOUT), 4'($urandom),
                1'($urandom), 1'b1, 8'($urandom));
    end

    reset_mid_stream();
    run_frame(0, 30, 4'd2, 1'b0, 1'b0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
